// File: rtl/mem_port_arbiter.sv
// Three-requester memory port arbiter (dc_write > dc_read > ic_read) with one outstanding access.
// Optional I-side starvation guard enabled by defining MEM_ARB_FAIR_EN.

`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef WIDTH
`define WIDTH 64
`endif

module mem_port_arbiter (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ic_read_req,
    input  logic [`REG_SIZE-1:0] ic_read_addr,
    output logic [`WIDTH-1:0]    ic_read_data,
    output logic                 ic_read_ack,
    input  logic                 dc_read_req,
    input  logic [`REG_SIZE-1:0] dc_read_addr,
    output logic [`WIDTH-1:0]    dc_read_data,
    output logic                 dc_read_ack,
    input  logic                 dc_write_req,
    input  logic [`REG_SIZE-1:0] dc_write_addr,
    input  logic [`WIDTH-1:0]    dc_write_data,
    output logic                 dc_write_ack,
    output logic                 mem_enable,
    output logic                 mem_rw,
    input  logic                 mem_ack,
    output logic [`REG_SIZE-1:0] mem_addr,
    input  logic [`WIDTH-1:0]    mem_data_in,
    output logic [`WIDTH-1:0]    mem_data_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_IC_RD = 2'd1, G_DC_RD = 2'd2, G_DC_WR = 2'd3} grant_t;

    state_t                 state_r, state_s;
    grant_t                 grant_r, grant_s, pick_s;
    logic                   enable_r, enable_s, rw_r, rw_s;
    logic [`REG_SIZE-1:0]   addr_r, addr_s;
    logic [`WIDTH-1:0]      wdata_r, wdata_s, ic_data_r, ic_data_s, dc_data_r, dc_data_s;
    logic                   ic_ack_r, ic_ack_s, dr_ack_r, dr_ack_s, dw_ack_r, dw_ack_s;
    logic                   force_ic_s;
    logic [1:0]             fair_cnt_r, fair_cnt_s;

`ifdef MEM_ARB_FAIR_EN
    assign force_ic_s = (fair_cnt_r == 2'd2) && ic_read_req;
`else
    assign force_ic_s = 1'b0;
`endif

    // Grant selection and next-state / next-output computation
    always_comb begin
        state_s    = state_r;
        grant_s    = grant_r;
        enable_s   = 1'b0;
        rw_s       = 1'b0;
        addr_s     = {`REG_SIZE{1'b0}};
        wdata_s    = {`WIDTH{1'b0}};
        ic_data_s  = ic_data_r;
        dc_data_s  = dc_data_r;
        ic_ack_s   = 1'b0;
        dr_ack_s   = 1'b0;
        dw_ack_s   = 1'b0;
        fair_cnt_s = fair_cnt_r;

        if (force_ic_s)        pick_s = G_IC_RD;
        else if (dc_write_req) pick_s = G_DC_WR;
        else if (dc_read_req)  pick_s = G_DC_RD;
        else if (ic_read_req)  pick_s = G_IC_RD;
        else                   pick_s = G_NONE;

        case (state_r)
            IDLE: begin
                if (pick_s != G_NONE) begin
                    state_s  = BUSY;
                    grant_s  = pick_s;
                    enable_s = 1'b1;
                    case (pick_s)
                        G_DC_WR: begin
                            rw_s    = 1'b1;
                            addr_s  = dc_write_addr;
                            wdata_s = dc_write_data;
                        end
                        G_DC_RD: addr_s = dc_read_addr;
                        G_IC_RD: addr_s = ic_read_addr;
                        default: addr_s = {`REG_SIZE{1'b0}};
                    endcase
                    // Run length of D grants that bypassed a waiting I request
                    if (pick_s == G_IC_RD)       fair_cnt_s = 2'd0;
                    else if (!ic_read_req)       fair_cnt_s = 2'd0;
                    else if (fair_cnt_r == 2'd2) fair_cnt_s = 2'd2;
                    else                         fair_cnt_s = fair_cnt_r + 2'd1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_s = RESP;
                    case (grant_r)
                        G_IC_RD: begin
                            ic_data_s = mem_data_in;
                            ic_ack_s  = 1'b1;
                        end
                        G_DC_RD: begin
                            dc_data_s = mem_data_in;
                            dr_ack_s  = 1'b1;
                        end
                        G_DC_WR: dw_ack_s = 1'b1;
                        default: state_s  = RESP;
                    endcase
                end else begin
                    enable_s = 1'b1;
                    rw_s     = rw_r;
                    addr_s   = addr_r;
                    wdata_s  = wdata_r;
                end
            end
            RESP: begin
                state_s = IDLE;
                grant_s = G_NONE;
            end
            default: begin
                state_s = IDLE;
                grant_s = G_NONE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= G_NONE;
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
        end
    end

    // Registered memory-side and requester-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            enable_r   <= 1'b0;
            rw_r       <= 1'b0;
            addr_r     <= {`REG_SIZE{1'b0}};
            wdata_r    <= {`WIDTH{1'b0}};
            ic_data_r  <= {`WIDTH{1'b0}};
            dc_data_r  <= {`WIDTH{1'b0}};
            ic_ack_r   <= 1'b0;
            dr_ack_r   <= 1'b0;
            dw_ack_r   <= 1'b0;
            fair_cnt_r <= 2'd0;
        end else begin
            enable_r   <= enable_s;
            rw_r       <= rw_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            ic_data_r  <= ic_data_s;
            dc_data_r  <= dc_data_s;
            ic_ack_r   <= ic_ack_s;
            dr_ack_r   <= dr_ack_s;
            dw_ack_r   <= dw_ack_s;
`ifdef MEM_ARB_FAIR_EN
            fair_cnt_r <= fair_cnt_s;
`else
            fair_cnt_r <= 2'd0;
`endif
        end
    end

    assign mem_enable   = enable_r;
    assign mem_rw       = rw_r;
    assign mem_addr     = addr_r;
    assign mem_data_out = wdata_r;
    assign ic_read_data = ic_data_r;
    assign dc_read_data = dc_data_r;
    assign ic_read_ack  = ic_ack_r;
    assign dc_read_ack  = dr_ack_r;
    assign dc_write_ack = dw_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; expectations follow MEM_ARB_FAIR_EN when defined.

`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef WIDTH
`define WIDTH 64
`endif

module tb_mem_port_arbiter;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ic_read_req, dc_read_req, dc_write_req, mem_ack;
    logic [`REG_SIZE-1:0] ic_read_addr, dc_read_addr, dc_write_addr, mem_addr;
    logic [`WIDTH-1:0]    ic_read_data, dc_read_data, dc_write_data, mem_data_in, mem_data_out;
    logic                 ic_read_ack, dc_read_ack, dc_write_ack, mem_enable, mem_rw;

    int n_cmp = 0;
    int n_err = 0;
    int cnt_ic = 0, cnt_dr = 0, cnt_dw = 0;
    int s_ic, s_dr, s_dw;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
        .ic_read_data(ic_read_data), .ic_read_ack(ic_read_ack),
        .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
        .dc_read_data(dc_read_data), .dc_read_ack(dc_read_ack),
        .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
        .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Running ack tallies per port
    always @(posedge clk) begin
        if (ic_read_ack)  cnt_ic++;
        if (dc_read_ack)  cnt_dr++;
        if (dc_write_ack) cnt_dw++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Serve one memory transaction: ack arrives lat cycles after the first enable cycle
    task automatic mem_txn(input string tag, input logic exp_rw, input logic [31:0] exp_addr,
                           input logic [63:0] exp_wdata, input logic [63:0] rdata, input int lat,
                           input logic [2:0] exp_ack, input bit drop);
        int n = 0;
        while (mem_enable !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check_eq({tag, " enable"}, 64'(mem_enable), 64'd1);
        check_eq({tag, " rw"}, 64'(mem_rw), 64'(exp_rw));
        check_eq({tag, " addr"}, 64'(mem_addr), 64'(exp_addr));
        check_eq({tag, " wdata"}, mem_data_out, exp_wdata);
        for (int i = 0; i < lat; i++) begin
            tick();
            check_eq({tag, " addr hold"}, 64'(mem_addr), 64'(exp_addr));
        end
        mem_ack = 1'b1;
        mem_data_in = rdata;
        tick();
        mem_ack = 1'b0;
        mem_data_in = 64'd0;
        check_eq({tag, " acks"}, 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'(exp_ack));
        check_eq({tag, " resp enable"}, 64'(mem_enable), 64'd0);
        check_eq({tag, " resp addr"}, 64'(mem_addr), 64'd0);
        if (exp_ack[2]) check_eq({tag, " ic data"}, ic_read_data, rdata);
        if (exp_ack[1]) check_eq({tag, " dc data"}, dc_read_data, rdata);
        if (drop) begin
            if (exp_ack[2]) ic_read_req = 1'b0;
            if (exp_ack[1]) dc_read_req = 1'b0;
            if (exp_ack[0]) dc_write_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ic_read_req = 1'b0; dc_read_req = 1'b0; dc_write_req = 1'b0; mem_ack = 1'b0;
        ic_read_addr = 32'd0; dc_read_addr = 32'd0; dc_write_addr = 32'd0;
        dc_write_data = 64'd0; mem_data_in = 64'd0;
        tick(); tick();
        check_eq("rst enable", 64'(mem_enable), 64'd0);
        check_eq("rst acks", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        check_eq("rst addr", 64'(mem_addr), 64'd0);
        check_eq("rst ic data", ic_read_data, 64'd0);
        reset = 1'b0;
        tick();

        // Single I refill, ack 3 cycles after enable
        ic_read_req = 1'b1;
        ic_read_addr = 32'h0000_0040;
        tick();
        check_eq("i1 enable cycle1", 64'(mem_enable), 64'd1);
        mem_txn("i1", 1'b0, 32'h40, 64'd0, 64'hDEADBEEF_0000_0001, 3, 3'b100, 1'b1);
        tick();
        check_eq("i1 ack drop", 64'(ic_read_ack), 64'd0);
        check_eq("i1 data hold", ic_read_data, 64'hDEADBEEF_0000_0001);
        check_eq("i1 idle rw", 64'(mem_rw), 64'd0);

        // Contention: all three at once, minimum-latency first transaction
        s_ic = cnt_ic; s_dr = cnt_dr; s_dw = cnt_dw;
        dc_write_req = 1'b1; dc_write_addr = 32'h100; dc_write_data = 64'hA5A5_0000_1111_2222;
        dc_read_req = 1'b1;  dc_read_addr = 32'h180;
        ic_read_req = 1'b1;  ic_read_addr = 32'h200;
        mem_txn("c.wr", 1'b1, 32'h100, 64'hA5A5_0000_1111_2222, 64'd0, 0, 3'b001, 1'b1);
        mem_txn("c.dr", 1'b0, 32'h180, 64'd0, 64'h0123_4567_89AB_CDEF, 2, 3'b010, 1'b1);
        mem_txn("c.ir", 1'b0, 32'h200, 64'd0, 64'hCAFE_F00D_0000_0002, 1, 3'b100, 1'b1);
        tick(); tick();
        check_eq("c ic acks", 64'(cnt_ic - s_ic), 64'd1);
        check_eq("c dr acks", 64'(cnt_dr - s_dr), 64'd1);
        check_eq("c dw acks", 64'(cnt_dw - s_dw), 64'd1);
        check_eq("c i data kept", ic_read_data, 64'hCAFE_F00D_0000_0002);

        // Address change during BUSY must not reach the memory port
        dc_write_req = 1'b1; dc_write_addr = 32'h100; dc_write_data = 64'h0000_0000_0000_0077;
        tick();
        dc_write_addr = 32'h200;
        mem_txn("addr", 1'b1, 32'h100, 64'h77, 64'd0, 3, 3'b001, 1'b1);
        tick();

        // Reset in the 2nd BUSY cycle of a dc read
        dc_read_req = 1'b1; dc_read_addr = 32'h300;
        tick();
        check_eq("r busy1", 64'(mem_enable), 64'd1);
        tick();
        reset = 1'b1;
        dc_read_req = 1'b0;
        tick();
        check_eq("r enable", 64'(mem_enable), 64'd0);
        check_eq("r rw", 64'(mem_rw), 64'd0);
        check_eq("r addr", 64'(mem_addr), 64'd0);
        check_eq("r wdata", mem_data_out, 64'd0);
        check_eq("r acks", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        check_eq("r ic data", ic_read_data, 64'd0);
        check_eq("r dc data", dc_read_data, 64'd0);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        check_eq("r late ack", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        tick();
        check_eq("r late ack2", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        check_eq("r dc data2", dc_read_data, 64'd0);

        // Spurious mem_ack in IDLE
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("sp acks", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        check_eq("sp enable", 64'(mem_enable), 64'd0);
        tick();
        check_eq("sp acks2", 64'({ic_read_ack, dc_read_ack, dc_write_ack}), 64'd0);
        check_eq("sp enable2", 64'(mem_enable), 64'd0);

        // I held while D reads run back to back
        ic_read_req = 1'b1; ic_read_addr = 32'h400;
        dc_read_req = 1'b1; dc_read_addr = 32'h500;
        mem_txn("f.d1", 1'b0, 32'h500, 64'd0, 64'h11, 1, 3'b010, 1'b0);
        mem_txn("f.d2", 1'b0, 32'h500, 64'd0, 64'h22, 1, 3'b010, 1'b0);
`ifdef MEM_ARB_FAIR_EN
        mem_txn("f.i",  1'b0, 32'h400, 64'd0, 64'h33, 1, 3'b100, 1'b1);
        mem_txn("f.d3", 1'b0, 32'h500, 64'd0, 64'h44, 1, 3'b010, 1'b1);
`else
        mem_txn("f.d3", 1'b0, 32'h500, 64'd0, 64'h33, 1, 3'b010, 1'b1);
        mem_txn("f.i",  1'b0, 32'h400, 64'd0, 64'h44, 1, 3'b100, 1'b1);
`endif
        tick(); tick();
        check_eq("f idle enable", 64'(mem_enable), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
